// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage with a small in-order fetch queue. Fetches one
//   word per cycle from a combinational instruction memory and stores
//   {pc, instr} pairs until decode accepts them. A redirect flushes the queue
//   and restarts fetch at the word-aligned target.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   rst            : synchronous active-high reset
//   imem_addr      : byte address to the instruction memory (= fetch_pc)
//   imem_instr     : instruction word for imem_addr, same cycle
//   redirect_valid : branch/jump redirect request
//   redirect_pc    : redirect target byte address
//   out_valid      : queue head holds a valid instruction
//   out_ready      : decode accepts the head this cycle
//   out_instr      : instruction at the queue head
//   out_pc         : PC of out_instr
//   queue_count    : current occupancy
//   misalign_seen  : sticky flag, set by a redirect to a non-word address
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic [31:0]                    imem_addr,
    input  logic [31:0]                    imem_instr,
    input  logic                           redirect_valid,
    input  logic [31:0]                    redirect_pc,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    out_instr,
    output logic [31:0]                    out_pc,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
    output logic                           misalign_seen
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
    // Low bits forced to zero so fetch_pc stays word aligned even if the
    // parameter is set to an unaligned value.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [PW-1:0] head_reg, head_next;
    logic [PW-1:0] tail_reg, tail_next;
    logic [CW-1:0] count_reg, count_next;
    logic          misalign_reg, misalign_next;

    // Queue storage. Read combinationally at the head so out_* need no extra
    // register stage; entries are reset so out_* read 0 until the first push.
    logic [31:0] pc_q    [QUEUE_DEPTH];
    logic [31:0] instr_q [QUEUE_DEPTH];

    logic pop;
    logic push;
    logic full;

    assign full = (count_reg == DEPTH_C);
    assign pop  = (count_reg != '0) && out_ready;
    // A pop in the same cycle frees a slot, so a full queue can still accept.
    assign push = !redirect_valid && (!full || pop);

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        head_next     = head_reg;
        tail_next     = tail_reg;
        count_next    = count_reg;
        misalign_next = misalign_reg;

        if (redirect_valid) begin
            // Redirect wins over push and pop: flush and refetch from target.
            fetch_pc_next = {redirect_pc[31:2], 2'b00};
            head_next     = '0;
            tail_next     = '0;
            count_next    = '0;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_next = 1'b1;
            end
        end else begin
            if (push) begin
                fetch_pc_next = fetch_pc_reg + 32'd4;
                tail_next     = tail_reg + PW'(1);
            end
            if (pop) begin
                head_next = head_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg <= RESET_PC_ALIGNED;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            misalign_reg <= 1'b0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            count_reg    <= count_next;
            misalign_reg <= misalign_next;
        end
    end

    // One write port per entry, enabled when the tail points at it.
    generate
        for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    pc_q[gi]    <= '0;
                    instr_q[gi] <= '0;
                end else if (push && (tail_reg == PW'(gi))) begin
                    pc_q[gi]    <= fetch_pc_reg;
                    instr_q[gi] <= imem_instr;
                end
            end
        end
    endgenerate

    assign imem_addr     = fetch_pc_reg;
    assign out_valid     = (count_reg != '0);
    assign out_pc        = pc_q[head_reg];
    assign out_instr     = instr_q[head_reg];
    assign queue_count   = count_reg;
    assign misalign_seen = misalign_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Directed testbench for fetch_unit with a combinational 32-word program
//   image. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  queue_count;
    logic        misalign_seen;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [31:0] mem [32];

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr[6:2]];

    fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .queue_count    (queue_count),
        .misalign_seen  (misalign_seen)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + i;
        mem[0]  = 32'h0000_0013;
        mem[1]  = 32'h00a0_0093;
        mem[2]  = 32'h0140_0113;
        mem[14] = 32'h00c1_8463;
        mem[15] = 32'h0630_0693;
        mem[17] = 32'h1234_5737;
        mem[20] = 32'hfe00_06e3;

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;

        // Reset state and straight-line streaming
        step();
        step();
        check("rst_count",    32'(queue_count), 32'd0);
        check("rst_valid",    32'(out_valid), 32'd0);
        check("rst_addr",     imem_addr, 32'h0);
        check("rst_misalign", 32'(misalign_seen), 32'd0);
        check("rst_out_pc",   out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        rst = 1'b0;
        step();
        for (int i = 0; i <= 20; i++) begin
            check($sformatf("stream_valid_%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("stream_pc_%0d", i), out_pc, 32'(4 * i));
            check($sformatf("stream_instr_%0d", i), out_instr, mem[i]);
            step();
        end

        // Back-pressure: queue fills to 4, fetch stalls, then drains in order
        rst       = 1'b1;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("fill_count_%0d", k), 32'(queue_count), (k < 4) ? 32'(k) : 32'd4);
        end
        check("stall_addr",  imem_addr, 32'h10);
        check("stall_pc",    out_pc, 32'h0);
        check("stall_instr", out_instr, 32'h0000_0013);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_valid_%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("drain_pc_%0d", i), out_pc, 32'(4 * i));
            step();
        end
        check("drain_count", 32'(queue_count), 32'd4);

        // Redirect with three queued entries
        rst       = 1'b1;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
        step();
        step();
        step();
        check("pre_redir_count", 32'(queue_count), 32'd3);
        out_ready = 1'b1;
        redirect(32'h38);
        check("redir_valid", 32'(out_valid), 32'd0);
        check("redir_count", 32'(queue_count), 32'd0);
        check("redir_addr",  imem_addr, 32'h38);
        step();
        check("redir_pc0",    out_pc, 32'h38);
        check("redir_instr0", out_instr, 32'h00c1_8463);
        step();
        check("redir_pc1",    out_pc, 32'h3C);
        check("redir_instr1", out_instr, 32'h0630_0693);

        // Misaligned redirect and sticky flag; back-to-back redirects
        redirect(32'h45);
        check("mis_addr", imem_addr, 32'h44);
        check("mis_flag", 32'(misalign_seen), 32'd1);
        step();
        check("mis_pc",    out_pc, 32'h44);
        check("mis_instr", out_instr, 32'h1234_5737);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        step();
        redirect(32'h30);
        check("dbl_flag", 32'(misalign_seen), 32'd1);
        check("dbl_addr", imem_addr, 32'h30);
        step();
        check("dbl_pc",    out_pc, 32'h30);
        check("dbl_count", 32'(queue_count), 32'd1);

        // Reset mid-stream with a full queue
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("full_count", 32'(queue_count), 32'd4);
        check("full_addr",  imem_addr, 32'h40);
        rst = 1'b1;
        step();
        check("mrst_count",    32'(queue_count), 32'd0);
        check("mrst_valid",    32'(out_valid), 32'd0);
        check("mrst_addr",     imem_addr, 32'h0);
        check("mrst_misalign", 32'(misalign_seen), 32'd0);
        check("mrst_out_pc",   out_pc, 32'h0);
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        check("restart_pc0",    out_pc, 32'h0);
        check("restart_instr0", out_instr, 32'h0000_0013);
        step();
        check("restart_pc1", out_pc, 32'h4);

        // Redirect and pop together while full
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("rp_full_count", 32'(queue_count), 32'd4);
        check("rp_head_pc",    out_pc, 32'h4);
        out_ready = 1'b1;
        redirect(32'h40);
        check("rp_count0", 32'(queue_count), 32'd0);
        check("rp_valid0", 32'(out_valid), 32'd0);
        step();
        check("rp_count1", 32'(queue_count), 32'd1);
        check("rp_pc0",    out_pc, 32'h40);
        step();
        check("rp_pc1", out_pc, 32'h44);

        // 32-bit address wrap-around
        redirect(32'hFFFF_FFF8);
        check("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        step();
        check("wrap_pc0",   out_pc, 32'hFFFF_FFF8);
        check("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_pc1",   out_pc, 32'hFFFF_FFFC);
        check("wrap_addr2", imem_addr, 32'h0);
        step();
        check("wrap_pc2",    out_pc, 32'h0);
        check("wrap_instr2", out_instr, 32'h0000_0013);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 4: fetch queue entries; legal values are powers of two, 2 to 16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port imem_addr, output, 32 bits: byte address to the combinational instruction memory.
REQ-006 SHALL have port imem_instr, input, 32 bits: instruction word returned for imem_addr in the same cycle.
REQ-007 SHALL have port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-008 SHALL have port redirect_pc, input, 32 bits: redirect target byte address.
REQ-009 SHALL have port out_valid, output, 1 bit: queue head holds a valid instruction.
REQ-010 SHALL have port out_ready, input, 1 bit: decode accepts the head this cycle.
REQ-011 SHALL have port out_instr, output, 32 bits: instruction at the queue head.
REQ-012 SHALL have port out_pc, output, 32 bits: PC of out_instr.
REQ-013 SHALL have port queue_count, output, clog2(QUEUE_DEPTH)+1 bits: current occupancy.
REQ-014 SHALL have port misalign_seen, output, 1 bit: sticky flag, set by a redirect with redirect_pc[1:0] != 0.

Function
REQ-015 SHALL hold fetch_pc in a register and drive imem_addr = fetch_pc combinationally; fetch_pc[1:0] SHALL always be 00.
REQ-016 SHALL define pop = out_valid && out_ready.
REQ-017 SHALL define push = !redirect_valid && (queue_count < QUEUE_DEPTH || pop).
REQ-018 On push, SHALL write {fetch_pc, imem_instr} at the tail and set fetch_pc <= fetch_pc + 4, with 32-bit wrap-around (0xFFFF_FFFC + 4 = 0).
REQ-019 SHALL keep fetch_pc and imem_addr unchanged while the queue is full and no pop occurs.
REQ-020 On pop, SHALL advance the head pointer; simultaneous push and pop SHALL leave queue_count unchanged.
REQ-021 SHALL assert out_valid iff queue_count != 0; out_instr and out_pc SHALL come directly from the head entry (no extra register stage).
REQ-022 Head and tail pointers SHALL wrap modulo QUEUE_DEPTH.
REQ-023 Redirect SHALL take priority over push and pop in the same cycle:
- flush the queue (count = 0, pointers = 0);
- set fetch_pc <= {redirect_pc[31:2], 2'b00};
- push nothing that cycle.
REQ-024 After a redirect, the first redirected instruction SHALL appear on out_* one cycle later.
REQ-025 A redirect with redirect_pc[1:0] != 0 SHALL set misalign_seen; the flag SHALL clear only on rst.
REQ-026 Consecutive redirects SHALL each flush; only the last target is fetched.
REQ-027 Latency: the word at fetch_pc SHALL appear at the head no earlier than one cycle after fetch.
REQ-028 With out_ready held at 1, throughput SHALL be one instruction per cycle.
REQ-029 Entries SHALL leave the queue in the same order they were pushed.

Reset
REQ-030 While rst=1, SHALL hold fetch_pc = RESET_PC, queue_count = 0, out_valid = 0, misalign_seen = 0, and pointers = 0; no push.
REQ-031 rst SHALL override redirect, push and pop in the same cycle; asserting rst mid-stream SHALL discard all queued entries.
REQ-032 out_instr and out_pc SHALL read 0 after reset until the first push.
REQ-033 The first push after rst deasserts SHALL fetch RESET_PC; out_valid SHALL rise on the next cycle.

Verification
REQ-034 Reset, then out_ready=1, imem loaded with program_2 image -> out_pc/out_instr = 0x00/00000013, 0x04/00a00093, 0x08/01400113, ... 0x50/fe0006e3 on consecutive cycles.
REQ-035 out_ready=0 for 8 cycles after reset -> queue_count saturates at 4; imem_addr holds 0x10; head stays 0x00/00000013; then out_ready=1 -> entries 0x00..0x0C drain in order with no gap.
REQ-036 Redirect to 0x38 while queue_count=3 and out_ready=1 -> out_valid=0 for one cycle, then 0x38/00c18463, 0x3C/06300693.
REQ-037 Redirect to 0x45 -> fetch from 0x44 (12345737); misalign_seen=1 and it stays set through later redirects until rst.
REQ-038 rst pulsed mid-stream with queue_count=4 -> next cycle queue_count=0, out_valid=0, imem_addr=RESET_PC; stream restarts at 0x00/00000013.
REQ-039 Redirect and pop in the same cycle while full -> popped entry is not repeated, flushed entries never appear, and queue_count=0 then 1.
